// File: rtl/hci_core_spill_slice_if.sv
// HCI core interface bundle: request/grant, response valid/ready and the
// handshake-ECC side signals, with initiator/target views.
interface hci_core_intf #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned BW  = 8,
    parameter int unsigned UW  = 1,
    parameter int unsigned IW  = 1,
    parameter int unsigned EW  = 1,
    parameter int unsigned EHW = 1
) ();
    localparam int unsigned BEW = DW / BW;

    logic           req;
    logic           gnt;
    logic [AW-1:0]  add;
    logic           wen;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic [UW-1:0]  user;
    logic [IW-1:0]  id;
    logic [EW-1:0]  ecc;
    logic           r_valid;
    logic           r_ready;
    logic [DW-1:0]  r_data;
    logic [UW-1:0]  r_user;
    logic [IW-1:0]  r_id;
    logic           r_opc;
    logic [EW-1:0]  r_ecc;
    logic [EHW-1:0] ereq;
    logic [EHW-1:0] egnt;
    logic [EHW-1:0] r_evalid;
    logic [EHW-1:0] r_eready;

    modport initiator (
        output req, add, wen, data, be, user, id, ecc, r_ready, ereq, r_eready,
        input  gnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
    );

    modport target (
        input  req, add, wen, data, be, user, id, ecc, r_ready, ereq, r_eready,
        output gnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
    );
endinterface

// File: rtl/hci_core_spill_slice.sv
// Registered cut between an HCI core initiator and target: request and response each
// pass a 2-entry spill buffer. Optional in-flight limit: HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN.

// Handshake rule on both sides of the buffer: an item moves on a clock edge where
// valid and ready are both high; valid never waits for ready, ready is registered.
module hci_core_spill_slice_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         a_valid_q, a_valid_d;
    logic         b_valid_q, b_valid_d;
    logic [W-1:0] a_data_q, a_data_d;
    logic [W-1:0] b_data_q, b_data_d;
    logic         in_hs, out_hs;

    assign ready_o = ~b_valid_q;
    assign valid_o = a_valid_q;
    assign data_o  = a_data_q;
    assign in_hs   = valid_i & ~b_valid_q;
    assign out_hs  = a_valid_q & ready_i;

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (!a_valid_q) begin
            if (in_hs) begin
                a_valid_d = 1'b1;
                a_data_d  = data_i;
            end
        end else if (out_hs) begin
            if (b_valid_q) begin
                a_data_d = b_data_q;
                if (in_hs) begin
                    b_data_d = data_i;
                end else begin
                    b_valid_d = 1'b0;
                end
            end else if (in_hs) begin
                a_data_d = data_i;
            end else begin
                a_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            // Output stalled: the skid slot absorbs the item already granted.
            b_valid_d = 1'b1;
            b_data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else if (clear_i) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end
endmodule

module hci_core_spill_slice #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned BW              = 8,
    parameter int unsigned UW              = 1,
    parameter int unsigned IW              = 1,
    parameter int unsigned EW              = 1,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    hci_core_intf.target    tcdm_target,
    hci_core_intf.initiator tcdm_initiator
`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
    ,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
`endif
);
    localparam int unsigned BEW   = DW / BW;
    localparam int unsigned REQ_W = AW + 1 + DW + BEW + UW + IW + EW;
    localparam int unsigned RSP_W = DW + UW + IW + 1 + EW;

    logic [REQ_W-1:0] req_in, req_out;
    logic [RSP_W-1:0] rsp_in, rsp_out;
    logic             req_ready;
    logic             req_allow;
    logic             unused_hs_ecc;

    assign req_in = {tcdm_target.add, tcdm_target.wen, tcdm_target.data, tcdm_target.be,
                     tcdm_target.user, tcdm_target.id, tcdm_target.ecc};
    assign {tcdm_initiator.add, tcdm_initiator.wen, tcdm_initiator.data, tcdm_initiator.be,
            tcdm_initiator.user, tcdm_initiator.id, tcdm_initiator.ecc} = req_out;

    // Gating valid as well as gnt keeps the buffer from taking an item the limit refused.
    hci_core_spill_slice_buf #(.W(REQ_W)) u_req_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .valid_i (tcdm_target.req & req_allow),
        .ready_o (req_ready),
        .data_i  (req_in),
        .valid_o (tcdm_initiator.req),
        .ready_i (tcdm_initiator.gnt),
        .data_o  (req_out)
    );

    assign tcdm_target.gnt = req_ready & req_allow;

    assign rsp_in = {tcdm_initiator.r_data, tcdm_initiator.r_user, tcdm_initiator.r_id,
                     tcdm_initiator.r_opc, tcdm_initiator.r_ecc};
    assign {tcdm_target.r_data, tcdm_target.r_user, tcdm_target.r_id,
            tcdm_target.r_opc, tcdm_target.r_ecc} = rsp_out;

    hci_core_spill_slice_buf #(.W(RSP_W)) u_rsp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .valid_i (tcdm_initiator.r_valid),
        .ready_o (tcdm_initiator.r_ready),
        .data_i  (rsp_in),
        .valid_o (tcdm_target.r_valid),
        .ready_i (tcdm_target.r_ready),
        .data_o  (rsp_out)
    );

    // Handshake-level ECC is not carried across the cut.
    assign tcdm_initiator.ereq     = '0;
    assign tcdm_initiator.r_eready = '0;
    assign tcdm_target.egnt        = '0;
    assign tcdm_target.r_evalid    = '0;
    assign unused_hs_ecc = ^{tcdm_target.ereq, tcdm_target.r_eready,
                             tcdm_initiator.egnt, tcdm_initiator.r_evalid};

`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_inc, cnt_dec;

    assign cnt_inc       = tcdm_target.req & tcdm_target.gnt;
    assign cnt_dec       = tcdm_target.r_valid & tcdm_target.r_ready;
    assign req_allow     = (cnt_q != CW'(MAX_OUTSTANDING));
    assign outstanding_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        !(cnt_dec && !cnt_inc && (cnt_q == '0)));
    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        !(cnt_inc && !cnt_dec && (cnt_q == CW'(MAX_OUTSTANDING))));
`endif
`else
    assign req_allow = 1'b1;
`endif
endmodule

// File: tb/tb_hci_core_spill_slice.sv
// Randomized bench for hci_core_spill_slice: each channel is modelled as an
// in-order queue of capacity 2 whose head is what the slice must present.
`timescale 1ns/1ps
module tb_hci_core_spill_slice;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned UW = 1;
    localparam int unsigned IW = 1;
    localparam int unsigned EW = 1;
`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
    localparam int unsigned MAXO = 2;
`else
    localparam int unsigned MAXO = 8;
`endif
    localparam int unsigned BEW   = DW / BW;
    localparam int unsigned REQ_W = AW + 1 + DW + BEW + UW + IW + EW;
    localparam int unsigned RSP_W = DW + UW + IW + 1 + EW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW), .IW(IW), .EW(EW)) up_if ();
    hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW), .IW(IW), .EW(EW)) dn_if ();

`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
    logic [$clog2(MAXO+1)-1:0] outstanding;
`endif

    hci_core_spill_slice #(
        .DW(DW), .AW(AW), .BW(BW), .UW(UW), .IW(IW), .EW(EW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .tcdm_target    (up_if),
        .tcdm_initiator (dn_if)
`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
        ,
        .outstanding_o  (outstanding)
`endif
    );

    // ---------------- scoreboard / model ----------------
    logic [REQ_W-1:0] exp_q[$];   // requests held by the slice, head = expected output
    logic [RSP_W-1:0] rsp_q[$];   // responses held by the slice
    logic [RSP_W-1:0] tgt_q[$];   // responses owed by the downstream target
    int               model_cnt = 0;
    int               n_vec = 0;
    int               n_err = 0;
    int               acc_cnt = 0;

    logic             up_pending = 1'b0;
    logic [REQ_W-1:0] up_item = '0;
    logic [AW-1:0]    addr_cnt = '0;
    logic             clr_next = 1'b0;
    logic             clr_seen = 1'b0;
    int unsigned      p_req = 0, p_dgnt = 0, p_rrdy = 0, p_rval = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [REQ_W-1:0] dn_req_payload();
        return {dn_if.add, dn_if.wen, dn_if.data, dn_if.be, dn_if.user, dn_if.id, dn_if.ecc};
    endfunction

    function automatic logic [RSP_W-1:0] up_rsp_payload();
        return {up_if.r_data, up_if.r_user, up_if.r_id, up_if.r_opc, up_if.r_ecc};
    endfunction

    // Downstream target's answer to a request: data folded with the address, tags echoed.
    function automatic logic [RSP_W-1:0] resp_of(input logic [REQ_W-1:0] r);
        logic [AW-1:0]  a;
        logic           w;
        logic [DW-1:0]  d;
        logic [BEW-1:0] b;
        logic [UW-1:0]  u;
        logic [IW-1:0]  i;
        logic [EW-1:0]  e;
        {a, w, d, b, u, i, e} = r;
        return {d ^ a, u, i, w, e};
    endfunction

    task automatic check_outputs();
        logic exp_gnt;
        exp_gnt = (exp_q.size() < 2);
`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
        exp_gnt = exp_gnt && (model_cnt != MAXO);
        check("outstanding", outstanding, model_cnt);
`endif
        check("up_gnt", up_if.gnt, exp_gnt);
        check("dn_req", dn_if.req, exp_q.size() > 0);
        if (exp_q.size() > 0) check("dn_payload", dn_req_payload(), exp_q[0]);
        check("dn_r_ready", dn_if.r_ready, rsp_q.size() < 2);
        check("up_r_valid", up_if.r_valid, rsp_q.size() > 0);
        if (rsp_q.size() > 0) check("up_rsp_payload", up_rsp_payload(), rsp_q[0]);
        check("hs_ecc_zero", {dn_if.ereq, dn_if.r_eready, up_if.egnt, up_if.r_evalid}, 0);
        if (clr_seen) begin
            check("clr_req", dn_if.req, 0);
            check("clr_r_valid", up_if.r_valid, 0);
            check("clr_gnt", up_if.gnt, 1);
            check("clr_r_ready", dn_if.r_ready, 1);
            clr_seen = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        logic           w;
        logic [DW-1:0]  d;
        logic [BEW-1:0] b;
        logic [UW-1:0]  u;
        logic [IW-1:0]  i;
        logic [EW-1:0]  e;
        clear    = clr_next;
        clr_next = 1'b0;
        if (!up_pending && ($urandom_range(99) < p_req)) begin
            w = 1'($urandom_range(1));
            d = DW'($urandom());
            b = BEW'($urandom());
            u = UW'($urandom());
            i = IW'($urandom());
            e = EW'($urandom());
            up_item    = {addr_cnt, w, d, b, u, i, e};
            addr_cnt   = addr_cnt + AW'(4);
            up_pending = 1'b1;
        end
        up_if.req = up_pending;
        {up_if.add, up_if.wen, up_if.data, up_if.be, up_if.user, up_if.id, up_if.ecc} = up_item;
        up_if.r_ready = ($urandom_range(99) < p_rrdy);
        dn_if.gnt     = ($urandom_range(99) < p_dgnt);
        if (tgt_q.size() > 0 && (dn_if.r_valid || ($urandom_range(99) < p_rval))) begin
            dn_if.r_valid = 1'b1;
            {dn_if.r_data, dn_if.r_user, dn_if.r_id, dn_if.r_opc, dn_if.r_ecc} = tgt_q[0];
        end else begin
            dn_if.r_valid = 1'b0;
        end
    endtask

    task automatic update_model();
        logic             up_req_hs, dn_req_hs, dn_rsp_hs, up_rsp_hs;
        logic [RSP_W-1:0] r;
        up_req_hs = up_if.req & up_if.gnt;
        dn_req_hs = dn_if.req & dn_if.gnt;
        dn_rsp_hs = dn_if.r_valid & dn_if.r_ready;
        up_rsp_hs = up_if.r_valid & up_if.r_ready;
        if (up_req_hs) up_pending = 1'b0;
        if (dn_req_hs) tgt_q.push_back(resp_of(dn_req_payload()));
        if (dn_rsp_hs) r = tgt_q.pop_front();
        if (clear) begin
            exp_q.delete();
            rsp_q.delete();
            model_cnt = 0;
            clr_seen  = 1'b1;
        end else begin
            if (dn_req_hs) void'(exp_q.pop_front());
            if (up_req_hs) begin
                exp_q.push_back(up_item);
                acc_cnt++;
            end
            if (up_rsp_hs) void'(rsp_q.pop_front());
            if (dn_rsp_hs) rsp_q.push_back(r);
            if (up_req_hs) model_cnt++;
            if (up_rsp_hs) model_cnt--;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_inputs();
        #1;
        update_model();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_p(input int unsigned rq, input int unsigned dg, input int unsigned rr,
                         input int unsigned rv);
        p_req = rq; p_dgnt = dg; p_rrdy = rr; p_rval = rv;
    endtask

    task automatic drain();
        int k;
        set_p(0, 100, 100, 100);
        for (k = 0; k < 100 && (up_pending || exp_q.size() > 0 || rsp_q.size() > 0
                                || tgt_q.size() > 0); k++) cycle();
        check("drain_done", exp_q.size() + rsp_q.size() + tgt_q.size() + int'(up_pending), 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dn_req", dn_if.req, 0);
        check("arst_up_gnt", up_if.gnt, 1);
        check("arst_up_r_valid", up_if.r_valid, 0);
        check("arst_dn_r_ready", dn_if.r_ready, 1);
        exp_q.delete(); rsp_q.delete(); tgt_q.delete();
        model_cnt = 0; up_pending = 1'b0; up_if.req = 1'b0; dn_if.r_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        up_if.req = 1'b0; up_if.add = '0; up_if.wen = 1'b0; up_if.data = '0; up_if.be = '0;
        up_if.user = '0; up_if.id = '0; up_if.ecc = '0; up_if.r_ready = 1'b0;
        up_if.ereq = '0; up_if.r_eready = '0;
        dn_if.gnt = 1'b0; dn_if.r_valid = 1'b0; dn_if.r_data = '0; dn_if.r_user = '0;
        dn_if.r_id = '0; dn_if.r_opc = 1'b0; dn_if.r_ecc = '0; dn_if.egnt = '0; dn_if.r_evalid = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_gnt", up_if.gnt, 1);
        check("rst_req", dn_if.req, 0);
        check("rst_r_valid", up_if.r_valid, 0);
        check("rst_r_ready", dn_if.r_ready, 1);
        check("rst_dn_payload", dn_req_payload(), 0);
        check("rst_up_rsp_payload", up_rsp_payload(), 0);

        // back-to-back stream from address 0
        set_p(100, 100, 100, 100);
        acc_cnt = 0;
        run(16);
        check("b2b_rate", acc_cnt, 16);
        drain();

        // downstream stall: only two requests fit
        set_p(100, 0, 100, 100);
        acc_cnt = 0;
        run(5);
        check("stall_accept", acc_cnt, 2);
        set_p(100, 100, 100, 100);
        run(6);
        drain();

        // upstream response backpressure
        set_p(100, 100, 0, 100);
        run(6);
        set_p(0, 100, 100, 100);
        run(4);
        drain();

        // directed write
        up_item = {AW'(32'h100), 1'b0, DW'(32'hDEADBEEF), BEW'(4'b0101), UW'(1), IW'(1), EW'(0)};
        up_pending = 1'b1;
        set_p(0, 0, 100, 100);
        for (k = 0; k < 20 && up_pending; k++) cycle();
        check("wr_accept", up_pending, 0);
        cycle();
        check("wr_data", dn_if.data, 32'hDEADBEEF);
        check("wr_be", dn_if.be, 4'b0101);
        check("wr_user_id", {dn_if.user, dn_if.id, dn_if.wen}, 3'b110);
        drain();

        // clear while idle, then during a stalled stream
        clr_next = 1'b1;
        cycle();
        run(2);
        set_p(100, 0, 100, 100);
        run(6);
        clr_next = 1'b1;
        cycle();
        run(2);
        drain();

`ifdef HCI_SPILL_SLICE_OUTSTANDING_LIMIT_EN
        set_p(100, 100, 100, 0);
        run(6);
        check("lim_outstanding", outstanding, MAXO);
        check("lim_gnt", up_if.gnt, 0);
        drain();
`endif

        // randomized mix, with an asynchronous reset in the middle
        for (int ph = 0; ph < 16; ph++) begin
            set_p($urandom_range(30, 100), $urandom_range(20, 100),
                  $urandom_range(20, 100), $urandom_range(20, 100));
            run(50);
            if (ph == 8) async_reset();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
